mac_out_buf: RTL and testbench

MAC_OUT_BUF -- requirements
Module: mac_out_buf

---
 rtl/mac_out_buf.sv | 239 +++++++++++++++++++++++
 tb/tb_mac_out_buf.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_out_buf.sv
// mac_out_buf: tags each MAC issue with its format, captures the result MAC_LAT cycles later into a
// credit-managed FIFO. Optional macro MAC_OUT_BUF_STAT_EN adds out_cnt, a 16-bit delivered-result counter.

module mac_out_buf_chk #(
    parameter int MAC_LAT = 3,
    parameter int DEPTH   = 4,
    parameter int CW      = 3
) (
    input logic               clk,
    input logic               rst_n,
    input logic               i_push,
    input logic               i_full,
    input logic [MAC_LAT-1:0] i_pipe_vld,
    input logic [CW-1:0]      i_fifo_cnt,
    input logic [CW-1:0]      i_credit
);
    // Each outstanding credit is either an operation in the MAC or an entry in the FIFO.
    a_credit_match: assert property (@(posedge clk) disable iff (!rst_n)
        ((CW+1)'($countones(i_pipe_vld)) + {1'b0, i_fifo_cnt}) == {1'b0, i_credit});

    a_credit_limit: assert property (@(posedge clk) disable iff (!rst_n)
        {1'b0, i_credit} <= (CW+1)'(DEPTH));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && i_full));
endmodule

module mac_out_buf #(
    parameter int MAC_LAT = 3,
    parameter int DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_fp_sel,
    input  logic [7:0]  result_int8,
    input  logic [15:0] result_fp16,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
`ifdef MAC_OUT_BUF_STAT_EN
    output logic [15:0] out_cnt,
`endif
    output logic        out_fp
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
    localparam logic [PW-1:0] PTR_ONE = PW'(1'b1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(1'b0);

    function automatic logic [15:0] fmt_word(input logic tag, input logic [7:0] r8,
                                             input logic [15:0] r16);
        logic [15:0] word;
        if (tag) begin
            word = r16;
        end else begin
            word = {{8{r8[7]}}, r8};
        end
        return word;
    endfunction

    logic [MAC_LAT-1:0] r_pipe_vld;
    logic [MAC_LAT-1:0] r_pipe_tag;
    logic [15:0]        r_mem_data [DEPTH];
    logic [DEPTH-1:0]   r_mem_fp;
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_fifo_cnt;
    logic [CW-1:0]      r_credit;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [15:0]        r_out_data;
    logic               r_out_fp;

    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic               w_push_fp;
    logic               w_full;
    logic [15:0]        w_push_data;
    logic [PW-1:0]      w_rd_ptr_nxt;
    logic [CW-1:0]      w_cnt_after_pop;
    logic [CW-1:0]      w_cnt_nxt;
    logic [CW-1:0]      w_credit_nxt;
    logic [15:0]        w_head_data_nxt;
    logic               w_head_fp_nxt;

    // Handshakes, occupancy/credit next-state and the next head word.
    always_comb begin
        w_accept        = in_valid & r_in_ready;
        w_pop           = r_out_valid & out_ready;
        w_push          = r_pipe_vld[MAC_LAT-1];
        w_push_fp       = r_pipe_tag[MAC_LAT-1];
        w_push_data     = fmt_word(w_push_fp, result_int8, result_fp16);
        w_full          = (r_fifo_cnt == DEPTH_C);
        w_rd_ptr_nxt    = r_rd_ptr;
        w_cnt_after_pop = r_fifo_cnt;
        w_cnt_nxt       = r_fifo_cnt;
        w_credit_nxt    = r_credit;
        w_head_data_nxt = r_out_data;
        w_head_fp_nxt   = r_out_fp;

        if (w_pop) begin
            w_rd_ptr_nxt    = r_rd_ptr + PTR_ONE;
            w_cnt_after_pop = r_fifo_cnt - CNT_ONE;
        end else begin
            w_rd_ptr_nxt    = r_rd_ptr;
            w_cnt_after_pop = r_fifo_cnt;
        end

        if (w_push) begin
            w_cnt_nxt = w_cnt_after_pop + CNT_ONE;
        end else begin
            w_cnt_nxt = w_cnt_after_pop;
        end

        if (w_accept && !w_pop) begin
            w_credit_nxt = r_credit + CNT_ONE;
        end else if (!w_accept && w_pop) begin
            w_credit_nxt = r_credit - CNT_ONE;
        end else begin
            w_credit_nxt = r_credit;
        end

        // A push into a FIFO that is empty after this cycle's pop becomes the head directly.
        if (w_push && (w_cnt_after_pop == CNT_ZERO)) begin
            w_head_data_nxt = w_push_data;
            w_head_fp_nxt   = w_push_fp;
        end else begin
            w_head_data_nxt = r_mem_data[w_rd_ptr_nxt];
            w_head_fp_nxt   = r_mem_fp[w_rd_ptr_nxt];
        end
    end

    // Valid/tag shift pipe mirroring the MAC latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= {MAC_LAT{1'b0}};
            r_pipe_tag <= {MAC_LAT{1'b0}};
        end else begin
            r_pipe_vld[0] <= w_accept;
            r_pipe_tag[0] <= in_fp_sel;
            for (int i = 1; i < MAC_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_tag[i] <= r_pipe_tag[i-1];
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= 16'h0000;
            end
            r_mem_fp <= {DEPTH{1'b0}};
        end else if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_fp[r_wr_ptr]   <= w_push_fp;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= PTR_ZERO;
            r_rd_ptr   <= PTR_ZERO;
            r_fifo_cnt <= CNT_ZERO;
        end else begin
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_fifo_cnt <= w_cnt_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
        end
    end

    // Registered head of the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 16'h0000;
            r_out_fp    <= 1'b0;
        end else begin
            r_out_valid <= (w_cnt_nxt != CNT_ZERO);
            r_out_data  <= w_head_data_nxt;
            r_out_fp    <= w_head_fp_nxt;
        end
    end

    // Credits; in_ready is registered so out_ready never reaches it combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit   <= CNT_ZERO;
            r_in_ready <= 1'b0;
        end else begin
            r_credit   <= w_credit_nxt;
            r_in_ready <= (w_credit_nxt < DEPTH_C);
        end
    end

`ifdef MAC_OUT_BUF_STAT_EN
    logic [15:0] r_out_cnt;

    // Delivered-result counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_cnt <= 16'h0000;
        end else if (w_pop) begin
            r_out_cnt <= r_out_cnt + 16'h0001;
        end
    end

    assign out_cnt = r_out_cnt;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_fp    = r_out_fp;

    mac_out_buf_chk #(
        .MAC_LAT (MAC_LAT),
        .DEPTH   (DEPTH),
        .CW      (CW)
    ) u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_push     (w_push),
        .i_full     (w_full),
        .i_pipe_vld (r_pipe_vld),
        .i_fifo_cnt (r_fifo_cnt),
        .i_credit   (r_credit)
    );
endmodule

// File: tb/tb_mac_out_buf.sv
// Scoreboard bench for mac_out_buf: random issue/consume traffic against a credit/queue model,
// plus a deeper-FIFO instance for sustained one-per-cycle throughput.
`timescale 1ns/1ps
module tb_mac_out_buf;
    localparam int MAC_LAT = 3;
    localparam int DEPTH   = 4;
    localparam int WDEPTH  = 8;

    typedef struct packed {
        logic [31:0] due;
        logic        fp;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_fp_sel;
    logic        out_ready;
    logic [7:0]  result_int8;
    logic [15:0] result_fp16;
    logic        in_ready, out_valid, out_fp;
    logic [15:0] out_data;
    logic        wd_in_ready, wd_out_valid, wd_out_fp;
    logic [15:0] wd_out_data;
`ifdef MAC_OUT_BUF_STAT_EN
    logic [15:0] out_cnt;
    logic [15:0] wd_out_cnt;
`endif

    always #5 clk = ~clk;

    mac_out_buf #(.MAC_LAT(MAC_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fp_sel(in_fp_sel), .result_int8(result_int8), .result_fp16(result_fp16),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef MAC_OUT_BUF_STAT_EN
        .out_cnt(out_cnt),
`endif
        .out_fp(out_fp)
    );

    mac_out_buf #(.MAC_LAT(MAC_LAT), .DEPTH(WDEPTH)) dut_wide (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(wd_in_ready),
        .in_fp_sel(in_fp_sel), .result_int8(result_int8), .result_fp16(result_fp16),
        .out_valid(wd_out_valid), .out_ready(out_ready), .out_data(wd_out_data),
`ifdef MAC_OUT_BUF_STAT_EN
        .out_cnt(wd_out_cnt),
`endif
        .out_fp(wd_out_fp)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          m_credit = 0;
    int          m_fifo_n = 0;
    int          def_pops = 0;
    int          wd_pops = 0;
    op_t         pend_q[$];
    logic [16:0] sb_q[$];
    logic        fix_en = 1'b0;
    logic [7:0]  fix8 = 8'h00;
    logic [15:0] fix16 = 16'h0000;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // One clock of stimulus; the model tracks credits, results due from the MAC and FIFO fill.
    task automatic drive_cycle(input logic iv, input logic fp, input logic ordy);
        logic acc, pop, push;
        op_t  op;
        int   sx;
        in_valid    = iv;
        in_fp_sel   = fp;
        out_ready   = ordy;
        result_int8 = 8'($urandom);
        result_fp16 = 16'($urandom);
        push = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == 32'(cyc)) begin
            op = pend_q.pop_front();
            if (fix_en) begin
                result_int8 = fix8;
                result_fp16 = fix16;
            end
            push = 1'b1;
            if (op.fp) begin
                sb_q.push_back({1'b1, result_fp16});
            end else begin
                sx = int'($signed(result_int8));
                sb_q.push_back({1'b0, sx[15:0]});
            end
        end
        check("in_ready", 32'(in_ready), 32'(m_credit < DEPTH));
        check("out_valid", 32'(out_valid), 32'(m_fifo_n > 0));
        acc = iv && (m_credit < DEPTH);
        pop = (m_fifo_n > 0) && ordy;
        if (acc) begin
            op.due = 32'(cyc + MAC_LAT);
            op.fp  = fp;
            pend_q.push_back(op);
        end
        m_credit = m_credit + int'(acc) - int'(pop);
        m_fifo_n = m_fifo_n + int'(push) - int'(pop);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_fp", 32'(out_fp), 32'd0);
        check("rst_wide_valid", 32'(wd_out_valid), 32'd0);
        check("rst_wide_word", 32'({wd_out_fp, wd_out_data}), 32'd0);
`ifdef MAC_OUT_BUF_STAT_EN
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
`endif
        pend_q.delete();
        sb_q.delete();
        m_credit = 0;
        m_fifo_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rel_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic single_issue(input logic fp, input logic [15:0] exp_d, input string nm);
        drive_cycle(1'b1, fp, 1'b0);
        repeat (MAC_LAT) drive_cycle(1'b0, 1'b0, 1'b0);
        check({nm, "_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_data"}, 32'(out_data), 32'(exp_d));
        check({nm, "_fp"}, 32'(out_fp), 32'(fp));
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic fill_test(input string nm);
        int n_acc;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) check({nm, "_in_ready_c4"}, 32'(in_ready), 32'd0);
            if (in_ready) n_acc++;
            drive_cycle(1'b1, 1'($urandom), 1'b0);
        end
        check({nm, "_accepted"}, 32'(n_acc), 32'd4);
        repeat (4) drive_cycle(1'b0, 1'b0, 1'b0);
        check({nm, "_full_valid"}, 32'(out_valid), 32'd1);
        check({nm, "_full_ready"}, 32'(in_ready), 32'd0);
        repeat (10) drive_cycle(1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: scoreboard compare on every handshake, plus head stability while stalled.
    initial begin : monitor
        logic [16:0] exp_w;
        logic        hold_pend;
        logic [16:0] hold_word;
        hold_pend = 1'b0;
        hold_word = 17'h00000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pend = 1'b0;
                def_pops  = 0;
                wd_pops   = 0;
            end else begin
                if (hold_pend) begin
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_word", 32'({out_fp, out_data}), 32'(hold_word));
                end
                if (out_valid && out_ready) begin
                    def_pops++;
                    check("pop_expected", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        exp_w = sb_q.pop_front();
                        check("out_data", 32'(out_data), 32'(exp_w[15:0]));
                        check("out_fp", 32'(out_fp), 32'(exp_w[16]));
                    end
                end
                if (wd_out_valid && out_ready) wd_pops++;
                hold_pend = out_valid && !out_ready;
                hold_word = {out_fp, out_data};
            end
        end
    end

    initial begin : stimulus
        rst_n       = 1'b1;
        in_valid    = 1'b0;
        in_fp_sel   = 1'b0;
        out_ready   = 1'b0;
        result_int8 = 8'h00;
        result_fp16 = 16'h0000;
        #2;
        do_reset();

        fix_en = 1'b1;
        fix8   = 8'hF3;
        fix16  = 16'h1234;
        single_issue(1'b0, 16'hFFF3, "int8");
        fix8   = 8'h5A;
        fix16  = 16'h3C00;
        single_issue(1'b1, 16'h3C00, "fp16");
        fix_en = 1'b0;

        fill_test("fill");

        for (int i = 0; i < 1500; i++) begin
            drive_cycle(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 9) < 6));
        end
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            check("wide_in_ready", 32'(wd_in_ready), 32'd1);
            if (i >= MAC_LAT + 1) check("wide_out_valid", 32'(wd_out_valid), 32'd1);
            drive_cycle(1'b1, 1'($urandom), 1'b1);
        end
        repeat (20) drive_cycle(1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'($urandom), 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        do_reset();
        repeat (10) drive_cycle(1'b0, 1'b0, 1'b1);
        fill_test("fill_after_rst");
        repeat (10) drive_cycle(1'b0, 1'b0, 1'b1);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

`ifdef MAC_OUT_BUF_STAT_EN
        do_reset();
        begin : stat_blk
            int guard;
            guard = 0;
            while (wd_pops < 65537 && guard < 70000) begin
                drive_cycle(1'b1, 1'($urandom), 1'b1);
                guard++;
            end
        end
        check("stat_budget", 32'(wd_pops >= 65537), 32'd1);
        check("wide_out_cnt", 32'(wd_out_cnt), 32'd1);
        check("out_cnt", 32'(out_cnt), 32'(def_pops[15:0]));
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
